// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Package : add_pkg
// Brief   : Shared defaults and the per-stage record for the pipelined adder.
// Rev     : 1.0 - initial release
// ============================================================================
package add_pkg;

  localparam int ADD_WIDTH   = 32;
  localparam int ADD_STAGES  = 4;
  localparam int ADD_SLICE_W = ADD_WIDTH / ADD_STAGES;

  // Operand words travel whole; each stage only reads its own slice of them.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [ADD_WIDTH-1:0] psum;
    logic [ADD_WIDTH-1:0] op1;
    logic [ADD_WIDTH-1:0] op2;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/add32_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : add32_pipe_if
// Brief     : Operand and result valid/ready streams of the pipelined adder.
// Rev       : 1.0 - initial release
// ============================================================================
interface add32_pipe_if #(
  parameter int WIDTH = add_pkg::ADD_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, op1, op2, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op1, op2, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/add_slice.sv
`default_nettype none
// ============================================================================
// Module : add_slice
// Brief  : W-bit combinational adder slice with carry out and carry into MSB.
// Rev    : 1.0 - initial release
// ============================================================================
module add_slice #(
  parameter int W = add_pkg::ADD_SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s      = w_full[W-1:0];
  assign co     = w_full[W];
  // The MSB sum bit is a^b^carry_in, so the incoming carry falls out directly.
  assign c_msb  = w_full[W-1] ^ a[W-1] ^ b[W-1];

endmodule
`default_nettype wire

// File: rtl/add32_pipe.sv
`default_nettype none
// ============================================================================
// Module : add32_pipe
// Brief  : Pipelined two's-complement adder, one carry slice per stage.
// Rev    : 1.0 - initial release
// ============================================================================
module add32_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH,
  parameter int STAGES = ADD_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  add32_pipe_if.slave   bus
);

  localparam int W = WIDTH / STAGES;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("add32_pipe: WIDTH must be a multiple of STAGES");
  end
  if (WIDTH != ADD_WIDTH) begin : g_bad_width
    $error("add32_pipe: WIDTH must match add_pkg::ADD_WIDTH (stage_t sizing)");
  end

  logic w_adv;
  logic r_cmsb;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t       r_stg;
    stage_t       w_nxt;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_s;
    logic         w_ci;
    logic         w_co;
    logic         w_cmsb;

    if (k == 0) begin : g_first
      assign w_a  = bus.op1[W-1:0];
      assign w_b  = bus.op2[W-1:0];
      assign w_ci = bus.cin;

      always_comb begin
        w_nxt            = '0;
        w_nxt.valid      = bus.in_valid;
        w_nxt.carry      = w_co;
        w_nxt.psum[W-1:0] = w_s;
        w_nxt.op1        = bus.op1;
        w_nxt.op2        = bus.op2;
      end
    end else begin : g_next
      assign w_a  = g_stage[k-1].r_stg.op1[k*W +: W];
      assign w_b  = g_stage[k-1].r_stg.op2[k*W +: W];
      assign w_ci = g_stage[k-1].r_stg.carry;

      always_comb begin
        w_nxt                  = g_stage[k-1].r_stg;
        w_nxt.carry            = w_co;
        w_nxt.psum[k*W +: W]   = w_s;
      end
    end

    add_slice #(.W(W)) u_slice (
      .a     (w_a),
      .b     (w_b),
      .ci    (w_ci),
      .s     (w_s),
      .co    (w_co),
      .c_msb (w_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stg <= '0;
      end else if (w_adv) begin
        r_stg <= w_nxt;
      end
    end

    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cmsb <= 1'b0;
        end else if (w_adv) begin
          r_cmsb <= w_cmsb;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].r_stg.valid;
  assign bus.sum       = g_stage[STAGES-1].r_stg.psum;
  assign bus.cout      = g_stage[STAGES-1].r_stg.carry;
  assign bus.ovf       = r_cmsb ^ g_stage[STAGES-1].r_stg.carry;

endmodule
`default_nettype wire

// File: tb/tb_add32_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_add32_pipe
// Brief  : Scoreboard bench for add32_pipe with a plain-arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_add32_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add32_pipe_if #(.WIDTH(32)) bus ();

  add32_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [33:0] exp;   // {cout, ovf, sum}
    int          acc;
    bit          lat;
  } item_t;

  item_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  bit    done   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    longint unsigned t;
    logic [31:0]     s;
    logic            co;
    logic            ov;
    t  = longint'(a) + longint'(b) + longint'(c);
    s  = t[31:0];
    co = t[32];
    ov = (a[31] == b[31]) && (s[31] != a[31]);
    return {co, ov, s};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [33:0] e, input bit lat);
    int    w;
    item_t it;
    w = 0;
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.cin      = c;
    #1;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (bus.in_ready) begin
      it.exp = e;
      it.acc = cyc;
      it.lat = lat;
      exp_q.push_back(it);
    end else begin
      check(1'b0, "accept_timeout", 64'(w), 64'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    a = $urandom;
    b = $urandom;
    c = 1'($urandom_range(0, 1));
    send(a, b, c, model(a, b, c), lat);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output transfer and watches stalls.
  initial begin : monitor
    item_t       it;
    bit          held;
    logic [33:0] hv;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (held)
          check(bus.out_valid && ({bus.cout, bus.ovf, bus.sum} == hv), "stall_hold",
                {29'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum}, {29'd0, 1'b1, hv});
        check(bus.in_ready == (!bus.out_valid || bus.out_ready), "in_ready",
              64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_result", {30'd0, bus.cout, bus.ovf, bus.sum}, 64'd0);
          end else begin
            it = exp_q.pop_front();
            check({bus.cout, bus.ovf, bus.sum} == it.exp, "result",
                  {30'd0, bus.cout, bus.ovf, bus.sum}, {30'd0, it.exp});
            if (it.lat)
              check((cyc - it.acc) == 4, "latency", 64'(cyc - it.acc), 64'd4);
          end
        end
        held = bus.out_valid && !bus.out_ready;
        hv   = {bus.cout, bus.ovf, bus.sum};
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [31:0] da [7];
    logic [31:0] db [7];
    logic        dc [7];
    logic [33:0] de [7];
    int          t;

    da = '{32'h4,        32'h4,        32'hFFFFFFF9, 32'h7,
           32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    db = '{32'h7,        32'hFFFFFFF8, 32'h00000003, 32'hFFFFFFFB,
           32'h1,        32'h1,        32'h80000000};
    dc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    de = '{{2'b00, 32'h0000000B}, {2'b00, 32'hFFFFFFFD}, {2'b00, 32'hFFFFFFFD},
           {2'b10, 32'h00000003}, {2'b10, 32'h00000000}, {2'b01, 32'h80000000},
           {2'b11, 32'h00000000}};

    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check({bus.out_valid, bus.cout, bus.ovf, bus.sum} == 35'd0, "reset_outputs",
          {29'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum}, 64'd0);
    check(bus.in_ready == 1'b1, "reset_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, including subtraction via complement and carry ripple
    for (int i = 0; i < 7; i++) send(da[i], db[i], dc[i], de[i], 1'b1);
    idle(6);

    // Back-to-back streaming
    repeat (8) send_rand(1'b1);
    idle(6);

    // Random bubbles, no stalls
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      else send_rand(1'b1);
    end
    idle(6);

    // Five-cycle backpressure once the first result shows up
    fork
      begin
        repeat (8) send_rand(1'b0);
      end
      begin
        t = 0;
        while (!bus.out_valid && t < 30) begin
          @(negedge clk);
          t++;
        end
        check(bus.out_valid == 1'b1, "bp_first_result", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        repeat (5) begin
          #1;
          check(bus.in_ready == 1'b0, "bp_in_ready", 64'(bus.in_ready), 64'd0);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(12);
    check(exp_q.size() == 0, "bp_drain", 64'(exp_q.size()), 64'd0);

    // Random input gaps against random backpressure
    done = 1'b0;
    fork
      begin
        repeat (60) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send_rand(1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(12);
    check(exp_q.size() == 0, "random_drain", 64'(exp_q.size()), 64'd0);

    // Reset with a result presented and three more in flight
    repeat (5) send_rand(1'b1);
    check(bus.out_valid == 1'b1, "pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check({bus.out_valid, bus.cout, bus.ovf, bus.sum} == 35'd0, "async_reset",
          {29'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      check(bus.out_valid == 1'b0, "no_stale", 64'(bus.out_valid), 64'd0);
    end

    // Recovery after reset
    repeat (6) send_rand(1'b1);
    idle(8);
    check(exp_q.size() == 0, "final_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add32_pipe.md
Name: add32_pipe

Overview:
- Pipelined 32-bit two's-complement adder. It is the addition counterpart of the team's combinational 32-bit subtractor and is the adder for the ALU datapath.
- The carry chain is split into STAGES slices, with one slice resolved per pipeline stage. Later operand slices are held in skew registers until their stage.
- Valid/ready handshake on input and output. A single global stall makes the block backpressure-safe.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, number of pipeline stages and carry slices. WIDTH % STAGES == 0 is required; elaborating with any other value is an error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op1/op2/cin are valid this cycle.
- in_ready  out  1  block accepts an operand set this cycle.
- op1  in  WIDTH  augend, two's complement.
- op2  in  WIDTH  addend, two's complement.
- cin  in  1  carry-in.
- out_valid  out  1  sum/cout/ovf are valid.
- out_ready  in  1  consumer takes the result this cycle.
- sum  out  WIDTH  op1+op2+cin, mod 2^WIDTH.
- cout  out  1  unsigned carry out of the MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: asynchronous assertion clears every stage valid bit. out_valid=0, sum=0, cout=0, ovf=0. All pipeline data registers are cleared to 0.
  - in_ready is combinational and evaluates to 1 during and after reset.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv.
  - When adv=1, every stage register loads from the stage before it; stage 0 loads from the inputs.
  - When adv=0, all stages hold.
  - Bubbles are not compressed while stalled.
- Accept: a transfer occurs when in_valid & in_ready. Stage-0 valid loads in_valid & adv.
- Slice width is W = WIDTH/STAGES.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of the operands, bits [k*W +: W], plus the carry registered by stage k-1. Stage 0 uses cin.
  - Registers the W-bit partial sum and the carry out.
  - Slices k+1 and above travel unmodified in skew registers.
  - Result slices 0..k-1 travel forward in registers.
- Final stage:
  - Also registers carry_into_msb, the carry into bit WIDTH-1 of its slice, for the ovf calculation.
  - sum is the concatenation of all slice results.
  - cout is the final-stage carry.
  - ovf = carry_into_msb ^ cout.
- Latency: a result is presented exactly STAGES cycles after acceptance, provided no stall occurs. With no stalls, throughput is 1 operation per cycle.
- Ordering: results leave in acceptance order. None are dropped or duplicated.
- Stall: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid stay stable, and in_ready=0.
- Simultaneous events: out_valid=1, out_ready=1 and in_valid=1 in the same cycle means the result leaves and the new operand set enters in that one cycle.
- Empty pipeline: out_valid=0 and in_ready=1 regardless of out_ready.
- in_valid=0 with adv=1 inserts a bubble, which appears as out_valid=0 STAGES cycles later.
- Reset mid-operation: all in-flight operations are discarded. After rst_n rises, no stale result is ever presented.
- Width rule: the addition is exact mod 2^WIDTH. Subtraction is expressed as op1 + ~op2 with cin=1 and must match the subtractor bit for bit.

Decomposition:
- Shared package add_pkg holds:
  - ADD_WIDTH=32 and ADD_STAGES=4 defaults;
  - the derived slice width;
  - a typedef for the per-stage record {valid, carry, partial sum, remaining op1/op2 slices}.
- One combinational sub-module, add_slice, is instantiated once per stage.
  - Parameter W.
  - Ports a, b, ci, s, co, c_msb.
  - c_msb is the carry into the slice MSB.

Test Plan:
- Basic add: op1=4, op2=7, cin=0, out_ready=1 -> after 4 cycles sum=0x0000000B, cout=0, ovf=0.
- Subtraction via complement, mirroring the subtractor vectors:
  - op1=4, op2=~7, cin=1 -> sum=0xFFFFFFFD (-3).
  - op1=-7, op2=~(-4), cin=1 -> sum=0xFFFFFFFD.
  - op1=7, op2=~4, cin=1 -> sum=3, cout=1.
- Carry ripple across all slices and overflow:
  - 0xFFFFFFFF+1 -> sum=0, cout=1, ovf=0.
  - 0x7FFFFFFF+1 -> sum=0x80000000, cout=0, ovf=1.
  - 0x80000000+0x80000000 -> sum=0, cout=1, ovf=1.
- Back-to-back streaming: 8 sets on consecutive cycles with out_ready=1 -> 8 results in order on 8 consecutive cycles, first one 4 cycles after the first accept.
- Backpressure: out_ready=0 for 5 cycles once the first result is presented -> in_ready=0, outputs held stable. Release -> all results delivered in order, none lost.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately. After release with no input, out_valid stays 0 for 10 cycles.
